// File: rtl/alu_cmd_sequencer.sv
// Issue stage for a combinational ALU.
// Commands (a, b, mode) enter through a valid/ready handshake into a Depth-entry FIFO.
// The FIFO head drives the ALU operand ports. The ALU result is registered into a single
// output slot, which has its own valid/ready handshake.
//
// Parameters:
//   DataWidth  operand/result width; must match the ALU instance
//   Depth      FIFO entries; power of two, at least 2
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake; cmd_a_i, cmd_b_i, cmd_mode_i payload
//   alu_a_o, alu_b_o,        head-of-FIFO operands to the ALU (zero when empty)
//   alu_mode_o
//   alu_result_i             combinational ALU result for the current head
//   rsp_valid_o/rsp_ready_i  response handshake; rsp_data_o, rsp_mode_o payload
//   level_o                  FIFO occupancy, 0..Depth
module alu_cmd_sequencer #(
  parameter int unsigned DataWidth = 100,
  parameter int unsigned Depth     = 4,
  localparam int unsigned PtrW     = $clog2(Depth),
  localparam int unsigned LvlW     = PtrW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DataWidth-1:0] cmd_a_i,
  input  logic [DataWidth-1:0] cmd_b_i,
  input  logic [1:0]           cmd_mode_i,
  output logic [DataWidth-1:0] alu_a_o,
  output logic [DataWidth-1:0] alu_b_o,
  output logic [1:0]           alu_mode_o,
  input  logic [DataWidth-1:0] alu_result_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic [1:0]           rsp_mode_o,
  output logic [LvlW-1:0]      level_o
);

  logic [DataWidth-1:0] mem_a_q    [Depth];
  logic [DataWidth-1:0] mem_b_q    [Depth];
  logic [1:0]           mem_mode_q [Depth];

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]      level_q, level_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]           rsp_mode_q, rsp_mode_d;

  logic empty, push, issue;

  assign empty = (level_q == '0);

  // A full FIFO never accepts, even if it pops this cycle (no pass-through path).
  // Gating with rst_ni keeps ready low while reset is held.
  assign cmd_ready_o = (level_q != LvlW'(Depth)) && rst_ni;
  assign push        = cmd_valid_i && cmd_ready_o;
  assign issue       = !empty && (!rsp_valid_q || rsp_ready_i);

  // The head is only meaningful when occupied. Zeroing the operands when empty keeps the
  // ALU inputs quiet and deterministic.
  assign alu_a_o    = empty ? '0 : mem_a_q[rd_ptr_q];
  assign alu_b_o    = empty ? '0 : mem_b_q[rd_ptr_q];
  assign alu_mode_o = empty ? '0 : mem_mode_q[rd_ptr_q];

  // Storage needs no reset: reads are masked by level_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a_q[wr_ptr_q]    <= cmd_a_i;
      mem_b_q[wr_ptr_q]    <= cmd_b_i;
      mem_mode_q[wr_ptr_q] <= cmd_mode_i;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mode_d  = rsp_mode_q;

    // Pointers wrap naturally because Depth is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end

    if (issue) begin
      rd_ptr_d    = rd_ptr_q + PtrW'(1);
      rsp_data_d  = alu_result_i;
      rsp_mode_d  = alu_mode_o;
      rsp_valid_d = 1'b1;
    end else if (rsp_ready_i) begin
      // The slot drains and nothing replaces it. The payload keeps its last value.
      rsp_valid_d = 1'b0;
    end

    case ({push, issue})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_mode_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mode_q  <= rsp_mode_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_mode_o  = rsp_mode_q;
  assign level_o     = level_q;

endmodule
